mem_arbiter_n: RTL and testbench

- N-channel arbiter between cache-side requesters and a single physical memory port.
- Generalises the two-channel instruction/data arbiter: parametrised channel count, line width and address width.
- Latches operation type at grant; one-hot grant; fixed or round-robin priority.
- Sits between the L1 caches/prefetcher and the pmem (burst/cacheline) interface.

---
 rtl/mem_arbiter_n_pkg.sv | 5 +
 rtl/mem_arbiter_n_picker.sv | 26 ++
 rtl/mem_arbiter_n.sv | 113 +++++++++++
 tb/tb_mem_arbiter_n.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_n_pkg.sv
// Shared types for the N-channel memory arbiter: controller state and latched operation.
package mem_arb_pkg;
   typedef enum logic {IDLE, BUSY} state_t;
   typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE} op_t;
endpackage

// File: rtl/mem_arbiter_n_picker.sv
// Combinational picker: first requester found when scanning upward from i_base, wrapping modulo NUM_CH.
module arb_picker
   import mem_arb_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int IDX_W  = 1
) (
   input  logic [NUM_CH-1:0] i_req,
   input  logic [IDX_W-1:0]  i_base,
   output logic [NUM_CH-1:0] o_grant
);
   logic w_found;

   always_comb begin
      o_grant = '0;
      w_found = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (!w_found && i_req[i] && (i == ((int'(i_base) + k) % NUM_CH))) begin
               o_grant[i] = 1'b1;
               w_found    = 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/mem_arbiter_n.sv
// N-channel arbiter onto one pmem port; fixed priority by default, round-robin when ARB_RR_EN is defined.
module mem_arbiter_n
   import mem_arb_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int LINE_W = 256,
   parameter int ADDR_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        ch_read,
   input  logic [NUM_CH-1:0]        ch_write,
   input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
   input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
   output logic [NUM_CH*LINE_W-1:0] ch_rdata,
   output logic [NUM_CH-1:0]        ch_resp,
   input  logic                     pmem_resp,
   input  logic [LINE_W-1:0]        pmem_rdata,
   output logic                     pmem_read,
   output logic                     pmem_write,
   output logic [ADDR_W-1:0]        pmem_address,
   output logic [LINE_W-1:0]        pmem_wdata
);
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   state_t            r_state;
   op_t               r_op;
   logic [NUM_CH-1:0] r_grant;
   logic [NUM_CH-1:0] w_pick;
   logic [IDX_W-1:0]  w_base;
   logic              w_busy;
   logic              w_rd;
   logic              w_wr;

`ifdef ARB_RR_EN
   logic [IDX_W-1:0] r_last;
   logic [IDX_W-1:0] w_gidx;

   always_comb begin
      w_gidx = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (r_grant[i]) w_gidx = IDX_W'(i);
      end
   end

   assign w_base = (r_last == IDX_W'(NUM_CH - 1)) ? '0 : r_last + 1'b1;

   // Only a completed transaction advances the rotation; reset abandons without updating.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last <= IDX_W'(NUM_CH - 1);
      end else if (r_state == BUSY && pmem_resp) begin
         r_last <= w_gidx;
      end
   end
`else
   assign w_base = '0;
`endif

   arb_picker #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_picker (
      .i_req   (ch_read | ch_write),
      .i_base  (w_base),
      .o_grant (w_pick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_op    <= OP_NONE;
      end else begin
         case (r_state)
            IDLE: begin
               if (|(ch_read | ch_write)) begin
                  r_grant <= w_pick;
                  r_op    <= (|(w_pick & ch_read)) ? OP_READ : OP_WRITE;
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               if (pmem_resp) begin
                  r_grant <= '0;
                  r_op    <= OP_NONE;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Outputs follow the latched op, so a requester dropping its strobe cannot abort the access.
   assign w_busy = (r_state == BUSY) && !rst;
   assign w_rd   = w_busy && (r_op == OP_READ);
   assign w_wr   = w_busy && (r_op == OP_WRITE);

   always_comb begin
      pmem_read    = w_rd;
      pmem_write   = w_wr;
      pmem_address = '0;
      pmem_wdata   = '0;
      ch_rdata     = '0;
      ch_resp      = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (r_grant[i] && w_busy) begin
            pmem_address = ch_addr[i*ADDR_W +: ADDR_W];
            if (w_wr) pmem_wdata = ch_wdata[i*LINE_W +: LINE_W];
            if (w_rd) ch_rdata[i*LINE_W +: LINE_W] = pmem_rdata;
            ch_resp[i] = pmem_resp;
         end
      end
   end
endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed bench for mem_arbiter_n (NUM_CH=2); expectations follow ARB_RR_EN when defined.
module tb_mem_arbiter_n;
   localparam int NUM_CH = 2;
   localparam int LINE_W = 256;
   localparam int ADDR_W = 32;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NUM_CH-1:0]        ch_read;
   logic [NUM_CH-1:0]        ch_write;
   logic [NUM_CH*ADDR_W-1:0] ch_addr;
   logic [NUM_CH*LINE_W-1:0] ch_wdata;
   logic [NUM_CH*LINE_W-1:0] ch_rdata;
   logic [NUM_CH-1:0]        ch_resp;
   logic                     pmem_resp;
   logic [LINE_W-1:0]        pmem_rdata;
   logic                     pmem_read;
   logic                     pmem_write;
   logic [ADDR_W-1:0]        pmem_address;
   logic [LINE_W-1:0]        pmem_wdata;

   int n_cmp = 0;
   int n_bad = 0;

   logic [LINE_W-1:0] c_a5;
   logic [LINE_W-1:0] c_5a;

   mem_arbiter_n #(.NUM_CH(NUM_CH), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .ch_read      (ch_read),
      .ch_write     (ch_write),
      .ch_addr      (ch_addr),
      .ch_wdata     (ch_wdata),
      .ch_rdata     (ch_rdata),
      .ch_resp      (ch_resp),
      .pmem_resp    (pmem_resp),
      .pmem_rdata   (pmem_rdata),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      @(negedge clk);
      n_cmp++; if (pmem_read !== 1'b0) begin n_bad++; $display("FAIL rst_read: got %b expected 0", pmem_read); end
      n_cmp++; if (pmem_write !== 1'b0) begin n_bad++; $display("FAIL rst_write: got %b expected 0", pmem_write); end
      n_cmp++; if (pmem_address !== '0) begin n_bad++; $display("FAIL rst_addr: got %h expected 0", pmem_address); end
      n_cmp++; if (ch_resp !== 2'b00) begin n_bad++; $display("FAIL rst_resp: got %b expected 00", ch_resp); end
      step();
      rst = 1'b0;
   endtask

   task automatic test_read();
      ch_read = 2'b01;
      ch_addr[31:0] = 32'h1000;
      step();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_cmp++; if (pmem_read !== 1'b1) begin n_bad++; $display("FAIL rd_strobe: got %b expected 1 (cycle %0d)", pmem_read, c); end
         n_cmp++; if (pmem_address !== 32'h1000) begin n_bad++; $display("FAIL rd_addr: got %h expected 1000", pmem_address); end
         n_cmp++; if (ch_resp !== 2'b00) begin n_bad++; $display("FAIL rd_early_resp: got %b expected 00", ch_resp); end
         step();
      end
      pmem_resp = 1'b1;
      pmem_rdata = c_a5;
      @(negedge clk);
      n_cmp++; if (pmem_read !== 1'b1) begin n_bad++; $display("FAIL rd_strobe3: got %b expected 1", pmem_read); end
      n_cmp++; if (ch_resp !== 2'b01) begin n_bad++; $display("FAIL rd_resp: got %b expected 01", ch_resp); end
      n_cmp++; if (ch_rdata[255:0] !== c_a5) begin n_bad++; $display("FAIL rd_data0: got %h expected %h", ch_rdata[255:0], c_a5); end
      n_cmp++; if (ch_rdata[511:256] !== '0) begin n_bad++; $display("FAIL rd_data1: got %h expected 0", ch_rdata[511:256]); end
      n_cmp++; if (pmem_write !== 1'b0) begin n_bad++; $display("FAIL rd_nowrite: got %b expected 0", pmem_write); end
      step();
      pmem_resp = 1'b0;
      pmem_rdata = '0;
      ch_read = 2'b00;
      @(negedge clk);
      n_cmp++; if (pmem_read !== 1'b0) begin n_bad++; $display("FAIL rd_idle: got %b expected 0", pmem_read); end
      n_cmp++; if (ch_rdata !== '0) begin n_bad++; $display("FAIL rd_idle_data: got %h expected 0", ch_rdata); end
      step();
   endtask

   task automatic test_write();
      ch_write = 2'b10;
      ch_addr[63:32] = 32'h2000;
      ch_wdata[511:256] = c_5a;
      step();
      @(negedge clk);
      n_cmp++; if (pmem_write !== 1'b1) begin n_bad++; $display("FAIL wr_strobe: got %b expected 1", pmem_write); end
      n_cmp++; if (pmem_read !== 1'b0) begin n_bad++; $display("FAIL wr_noread: got %b expected 0", pmem_read); end
      n_cmp++; if (pmem_address !== 32'h2000) begin n_bad++; $display("FAIL wr_addr: got %h expected 2000", pmem_address); end
      n_cmp++; if (pmem_wdata !== c_5a) begin n_bad++; $display("FAIL wr_data: got %h expected %h", pmem_wdata, c_5a); end
      step();
      pmem_resp = 1'b1;
      pmem_rdata = c_a5;
      @(negedge clk);
      n_cmp++; if (ch_resp !== 2'b10) begin n_bad++; $display("FAIL wr_resp: got %b expected 10", ch_resp); end
      n_cmp++; if (ch_rdata !== '0) begin n_bad++; $display("FAIL wr_rdata: got %h expected 0", ch_rdata); end
      step();
      pmem_resp = 1'b0;
      pmem_rdata = '0;
      ch_write = 2'b00;
      step();
   endtask

   task automatic test_contention();
      logic [1:0] exp_g [2];
      exp_g[0] = 2'b01;
`ifdef ARB_RR_EN
      exp_g[1] = 2'b10;
`else
      exp_g[1] = 2'b01;
`endif
      ch_read = 2'b11;
      ch_addr = {32'h4000, 32'h3000};
      for (int r = 0; r < 2; r++) begin
         step();
         pmem_resp = 1'b1;
         @(negedge clk);
         n_cmp++; if (ch_resp !== exp_g[r]) begin n_bad++; $display("FAIL cont_grant%0d: got %b expected %b", r, ch_resp, exp_g[r]); end
         n_cmp++; if (pmem_address !== (exp_g[r][0] ? 32'h3000 : 32'h4000)) begin n_bad++; $display("FAIL cont_addr%0d: got %h", r, pmem_address); end
         step();
         pmem_resp = 1'b0;
         @(negedge clk);
         n_cmp++; if (pmem_read !== 1'b0) begin n_bad++; $display("FAIL cont_gap%0d: got %b expected 0", r, pmem_read); end
      end
      ch_read = 2'b00;
      step();
      step();
   endtask

   task automatic test_read_write_both();
      ch_read = 2'b01;
      ch_write = 2'b01;
      ch_addr[31:0] = 32'h5000;
      ch_wdata[255:0] = c_5a;
      step();
      @(negedge clk);
      n_cmp++; if (pmem_read !== 1'b1) begin n_bad++; $display("FAIL rw_read: got %b expected 1", pmem_read); end
      n_cmp++; if (pmem_write !== 1'b0) begin n_bad++; $display("FAIL rw_write: got %b expected 0", pmem_write); end
      n_cmp++; if (pmem_wdata !== '0) begin n_bad++; $display("FAIL rw_wdata: got %h expected 0", pmem_wdata); end
      step();
      pmem_resp = 1'b1;
      step();
      pmem_resp = 1'b0;
      ch_read = 2'b00;
      ch_write = 2'b00;
      step();
   endtask

   task automatic test_reset_busy();
      ch_read = 2'b01;
      ch_addr[31:0] = 32'h6000;
      step();
      @(negedge clk);
      n_cmp++; if (pmem_read !== 1'b1) begin n_bad++; $display("FAIL rb_pre: got %b expected 1", pmem_read); end
      step();
      rst = 1'b1;
      ch_read = 2'b00;
      step();
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (pmem_read !== 1'b0) begin n_bad++; $display("FAIL rb_read: got %b expected 0", pmem_read); end
      n_cmp++; if (pmem_address !== '0) begin n_bad++; $display("FAIL rb_addr: got %h expected 0", pmem_address); end
      n_cmp++; if (ch_resp !== 2'b00) begin n_bad++; $display("FAIL rb_resp: got %b expected 00", ch_resp); end
      ch_write = 2'b10;
      ch_addr[63:32] = 32'h7000;
      ch_wdata[511:256] = c_a5;
      step();
      pmem_resp = 1'b1;
      @(negedge clk);
      n_cmp++; if (pmem_write !== 1'b1) begin n_bad++; $display("FAIL rb_new_write: got %b expected 1", pmem_write); end
      n_cmp++; if (pmem_address !== 32'h7000) begin n_bad++; $display("FAIL rb_new_addr: got %h expected 7000", pmem_address); end
      n_cmp++; if (ch_resp !== 2'b10) begin n_bad++; $display("FAIL rb_new_resp: got %b expected 10", ch_resp); end
      step();
      pmem_resp = 1'b0;
      ch_write = 2'b00;
      step();
   endtask

   task automatic test_drop_request();
      ch_read = 2'b01;
      ch_addr[31:0] = 32'h8000;
      step();
      step();
      ch_read = 2'b00;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_cmp++; if (pmem_read !== 1'b1) begin n_bad++; $display("FAIL drop_read%0d: got %b expected 1", c, pmem_read); end
         n_cmp++; if (pmem_address !== 32'h8000) begin n_bad++; $display("FAIL drop_addr%0d: got %h expected 8000", c, pmem_address); end
         step();
      end
      pmem_resp = 1'b1;
      @(negedge clk);
      n_cmp++; if (ch_resp !== 2'b01) begin n_bad++; $display("FAIL drop_resp: got %b expected 01", ch_resp); end
      step();
      pmem_resp = 1'b0;
      @(negedge clk);
      n_cmp++; if (pmem_read !== 1'b0) begin n_bad++; $display("FAIL drop_idle: got %b expected 0", pmem_read); end
      step();
   endtask

   task automatic test_idle_resp();
      pmem_resp = 1'b1;
      pmem_rdata = c_a5;
      @(negedge clk);
      n_cmp++; if (ch_resp !== 2'b00) begin n_bad++; $display("FAIL idle_resp: got %b expected 00", ch_resp); end
      n_cmp++; if (ch_rdata !== '0) begin n_bad++; $display("FAIL idle_rdata: got %h expected 0", ch_rdata); end
      step();
      pmem_resp = 1'b0;
      pmem_rdata = '0;
      step();
   endtask

   initial begin
      c_a5 = {32{8'hA5}};
      c_5a = {32{8'h5A}};
      rst = 1'b1;
      ch_read = '0;
      ch_write = '0;
      ch_addr = '0;
      ch_wdata = '0;
      pmem_resp = 1'b0;
      pmem_rdata = '0;
      test_reset();
      test_read();
      test_write();
      test_contention();
      test_read_write_both();
      test_reset_busy();
      test_drop_request();
      test_idle_resp();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
